event_scheduler_gen: RTL and testbench
======================================

Name: event_scheduler_gen

Overview:
- Parametrised timing-wheel clock generator; successor to the fixed 13-clock scheduler.
- Produces NUM_CLK divided clocks from clk_i, each with a runtime-programmable half-period.
- Adds per-channel enable with park-low, correct wheel wrap-around, and configuration error reporting.
- Feeds the emulation clock tree; freeze stalls every clock coherently.

Parameters:
- NUM_CLK, 13, number of generated clocks.
- DEPTH, 32, wheel slots; must be a power of 2 and greater than NUM_CLK+1.
- HP_W, 5, half-period field width; equals log2(DEPTH).

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- freeze  in  1  1 = hold all state (wheel, pointer, pipeline, outputs).
- ch_en_i  in  NUM_CLK  per-channel run enable; level, sampled every edge.
- cfg_we_i  in  1  half-period write strobe, one cycle.
- cfg_idx_i  in  $clog2(NUM_CLK)  channel index to write.
- cfg_hp_i  in  HP_W  new half-period, in clk_i cycles.
- cfg_err_o  out  1  registered one-cycle pulse on a rejected write.
- clk  out  NUM_CLK  generated clocks.
- clk_h  out  NUM_CLK  clk delayed by one active cycle.

Behaviour:
- Reset state:
  - wheel: all slots 0; ptr = 0; armed = 0.
  - clk_s, clk_u, clk and clk_h: all 0; cfg_err_o = 0.
  - hp[i] = NUM_CLK+1-i; with the defaults this gives 14 down to 2.
- Each active edge (freeze = 0), in this order:
  1. ev = wheel[ptr].
  2. For each i with ev[i] = 1:
     - if ch_en_i[i] = 1: toggle clk_s[i] and set bit i of wheel[(ptr+hp[i]) mod DEPTH].
     - if ch_en_i[i] = 0: clk_s[i] <= 0, no reschedule, armed[i] <= 0.
  3. For each i with ch_en_i[i] = 1 and armed[i] = 0 and ev[i] = 0: set bit i of wheel[(ptr+1) mod DEPTH] and set armed[i].
  4. wheel[ptr] <= 0; all new bits for other slots are OR-ed in. Multiple channels may target the same slot.
  5. ptr <= (ptr+1) mod DEPTH. Wraps DEPTH-1 -> 0; index DEPTH is never used.
- Output pipeline: clk_u <= clk_s; clk <= clk_u; clk_h <= clk.
  - clk follows a clk_s toggle by 2 edges; clk_h follows it by 3 edges.
- freeze = 1:
  - No state changes apart from half-period configuration; clocks resume phase-exact when freeze drops.
  - No arming occurs.
- hp range is 1 .. DEPTH-1. Because hp >= 1, a reschedule never targets the slot currently being processed, and a single mod wrap suffices.
- Configuration writes:
  - Accepted when cfg_idx_i < NUM_CLK and 1 <= cfg_hp_i <= DEPTH-1; hp[idx] updated on that edge.
  - Accepted regardless of freeze.
  - New value applies from that channel's next processed event; an already-scheduled slot is not moved.
  - Rejected writes leave hp unchanged and give cfg_err_o = 1 on the following cycle.
- Write in the same edge as that channel's event: the reschedule uses the old hp; the new hp applies from the event after.
- Enable behaviour:
  - Disable takes effect at the channel's next scheduled event; the output then parks low.
  - Re-enabling a parked channel first toggles high 1 active edge after arming, i.e. on the next edge.
- Reset asserted mid-operation clears everything immediately, asynchronously. Arming restarts on the first edge with rst_ni = 1.

Test Plan:
- Defaults, ch_en_i all 1, freeze 0, release reset (E1 = first edge):
  - clk_s all toggle at E2; clk all rise after E4; clk_h after E5.
  - clk[12] period 4 cycles; clk[0] period 28 cycles; 200 cycles checked against a reference model.
- Wrap-around: run more than 3*DEPTH cycles.
  - ptr sequences 31 -> 0 with no missed or duplicated toggles.
  - clk[1] (hp 13) keeps a 26-cycle period across every wrap.
- Runtime reprogram: write idx 12, hp 5 while clk[12] is running.
  - Current half-period stays 2; all subsequent half-periods are 5 (period 10).
  - A write of hp 0 or idx 13 pulses cfg_err_o for 1 cycle and leaves hp unchanged.
- Disable/enable: drop ch_en_i[3] while clk[3] = 1.
  - clk[3] goes 0 at its next event and stays 0.
  - Re-raise it: clk_s[3] toggles high 2 edges later and clk[3] runs at period 22.
- Freeze for 17 cycles mid-run: all clk and clk_h hold; on release the phase relationships are identical to an unfrozen trace shifted by 17 cycles.
- Assert rst_ni low between edges while clocks run: all outputs go 0 immediately; after release the start-up sequence repeats exactly.

Source files
------------

// File: rtl/event_scheduler_gen_if.sv
// event_scheduler_gen_if: half-period configuration port of the clock scheduler
interface event_scheduler_gen_if #(
  parameter int NUM_CLK = 13,
  parameter int HP_W = 5
);
  logic                       cfg_we_i;
  logic [$clog2(NUM_CLK)-1:0] cfg_idx_i;
  logic [HP_W-1:0]            cfg_hp_i;
  logic                       cfg_err_o;
  modport master (output cfg_we_i, cfg_idx_i, cfg_hp_i, input cfg_err_o);
  modport slave (input cfg_we_i, cfg_idx_i, cfg_hp_i, output cfg_err_o);
endinterface

// File: rtl/event_scheduler_gen.sv
// event_scheduler_gen: timing-wheel generator of NUM_CLK divided clocks with
// runtime-programmable half-periods, per-channel enable and coherent freeze
module event_scheduler_gen #(
  parameter int NUM_CLK = 13,
  parameter int DEPTH = 32,
  parameter int HP_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               freeze,
  input  logic [NUM_CLK-1:0] ch_en_i,
  event_scheduler_gen_if.slave cfg,
  output logic [NUM_CLK-1:0] clk,
  output logic [NUM_CLK-1:0] clk_h
);
  logic [NUM_CLK-1:0] wheel [DEPTH];
  logic [NUM_CLK-1:0] wheel_n [DEPTH];
  logic [HP_W-1:0] hp [NUM_CLK];
  logic [HP_W-1:0] ptr;
  logic [NUM_CLK-1:0] ev, armed, armed_n, clk_s, clk_s_n, clk_u;
  logic cfg_ok;
  assign cfg_ok = 32'(cfg.cfg_idx_i) < NUM_CLK && cfg.cfg_hp_i != '0;
  // hp >= 1 keeps every reschedule off the slot being cleared; ptr wraps naturally
  always_comb begin
    ev = wheel[ptr];
    wheel_n = wheel;
    armed_n = armed;
    clk_s_n = clk_s;
    wheel_n[ptr] = '0;
    for (int i = 0; i < NUM_CLK; i++)
      if (ev[i]) begin
        if (ch_en_i[i]) begin
          clk_s_n[i] = ~clk_s[i];
          wheel_n[ptr + hp[i]][i] = 1'b1;
        end else begin
          clk_s_n[i] = 1'b0;
          armed_n[i] = 1'b0;
        end
      end else if (ch_en_i[i] && !armed[i]) begin
        wheel_n[ptr + 1'b1][i] = 1'b1;
        armed_n[i] = 1'b1;
      end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int d = 0; d < DEPTH; d++) wheel[d] <= '0;
      for (int i = 0; i < NUM_CLK; i++) hp[i] <= HP_W'(NUM_CLK + 1 - i);
      ptr <= '0;
      armed <= '0;
      clk_s <= '0;
      clk_u <= '0;
      clk <= '0;
      clk_h <= '0;
      cfg.cfg_err_o <= 1'b0;
    end else begin
      if (cfg.cfg_we_i && cfg_ok) hp[cfg.cfg_idx_i] <= cfg.cfg_hp_i;
      cfg.cfg_err_o <= cfg.cfg_we_i && !cfg_ok;
      if (!freeze) begin
        wheel <= wheel_n;
        ptr <= ptr + 1'b1;
        armed <= armed_n;
        clk_s <= clk_s_n;
        clk_u <= clk_s;
        clk <= clk_u;
        clk_h <= clk;
      end
    end
endmodule

// File: tb/tb_event_scheduler_gen.sv
// tb_event_scheduler_gen: directed and randomized checks of the clock scheduler
// against an event-time reference model
module tb_event_scheduler_gen;
  localparam int N = 13, D = 32, W = 5;
  logic clk_i = 0, rst_ni = 0, freeze = 0;
  logic [N-1:0] ch_en = '1;
  logic [N-1:0] clk, clk_h;
  int checks = 0, errors = 0;
  event_scheduler_gen_if #(.NUM_CLK(N), .HP_W(W)) cfg ();
  event_scheduler_gen #(.NUM_CLK(N), .DEPTH(D), .HP_W(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .freeze(freeze), .ch_en_i(ch_en),
    .cfg(cfg), .clk(clk), .clk_h(clk_h));
  always #5 clk_i = ~clk_i;

  // model: each channel holds a pending flag and the absolute edge count of its next toggle
  int t, nt[N], mhp[N];
  bit pend[N];
  logic [N-1:0] ms, mu, mc, mh;
  logic merr;

  task automatic model_reset();
    t = 0; ms = '0; mu = '0; mc = '0; mh = '0; merr = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; nt[i] = 0; mhp[i] = N + 1 - i; end
  endtask

  task automatic model_edge();
    logic [N-1:0] ns;
    bit ok;
    ns = ms;
    ok = int'(cfg.cfg_idx_i) < N && cfg.cfg_hp_i != 0;
    if (!freeze) begin
      for (int i = 0; i < N; i++)
        if (pend[i] && nt[i] == t) begin
          if (ch_en[i]) begin ns[i] = ~ms[i]; nt[i] = t + mhp[i]; end
          else begin ns[i] = 0; pend[i] = 0; end
        end else if (ch_en[i] && !pend[i]) begin pend[i] = 1; nt[i] = t + 1; end
      mh = mc; mc = mu; mu = ms; ms = ns; t++;
    end
    merr = cfg.cfg_we_i && !ok;
    if (cfg.cfg_we_i && ok) mhp[cfg.cfg_idx_i] = int'(cfg.cfg_hp_i);
  endtask

  task automatic step();
    @(posedge clk_i);
    if (!rst_ni) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    cfg.cfg_we_i = 0; cfg.cfg_idx_i = '0; cfg.cfg_hp_i = '0;
    rst_ni = 0; model_reset();
    #22;
    checks++;
    if (clk !== '0 || clk_h !== '0 || cfg.cfg_err_o !== 1'b0) begin
      errors++; $display("FAIL reset clk %h clk_h %h err %b want 0", clk, clk_h, cfg.cfg_err_o);
    end
    @(negedge clk_i); rst_ni = 1;
  endtask

  task automatic test_startup();
    int r12 = -1, r0 = -1, p12 = 0, p0 = 0;
    logic [N-1:0] prev;
    step(); step(); step();
    checks++;
    if (clk !== '0) begin errors++; $display("FAIL startup_e3 clk %h want 0", clk); end
    step();
    checks++;
    if (clk !== '1 || clk_h !== '0) begin
      errors++; $display("FAIL startup_e4 clk %h clk_h %h want 1fff 0", clk, clk_h);
    end
    step();
    checks++;
    if (clk_h !== '1) begin errors++; $display("FAIL startup_e5 clk_h %h want 1fff", clk_h); end
    prev = clk;
    for (int c = 5; c < 200; c++) begin
      step();
      if (clk[12] && !prev[12]) begin if (r12 >= 0) p12 = c - r12; r12 = c; end
      if (clk[0] && !prev[0]) begin if (r0 >= 0) p0 = c - r0; r0 = c; end
      prev = clk;
      checks++;
      if (clk !== mc || clk_h !== mh) begin
        errors++; $display("FAIL startup_model cyc %0d clk %h/%h clk_h %h/%h", c, clk, mc, clk_h, mh);
      end
    end
    checks++;
    if (p12 != 4 || p0 != 28) begin
      errors++; $display("FAIL startup_period clk12 %0d want 4 clk0 %0d want 28", p12, p0);
    end
  endtask

  task automatic test_wrap();
    int r1 = -1, bad = 0, nrise = 0;
    logic pv;
    pv = clk[1];
    for (int c = 0; c < 3 * D + 20; c++) begin
      step();
      if (clk[1] && !pv) begin
        if (r1 >= 0 && c - r1 != 26) bad++;
        r1 = c; nrise++;
      end
      pv = clk[1];
      checks++;
      if (clk !== mc || clk_h !== mh) begin
        errors++; $display("FAIL wrap_model cyc %0d clk %h/%h clk_h %h/%h", c, clk, mc, clk_h, mh);
      end
    end
    checks++;
    if (bad != 0 || nrise < 4) begin
      errors++; $display("FAIL wrap_period bad_intervals %0d rises %0d want 0 and >=4", bad, nrise);
    end
  endtask

  task automatic test_reprogram();
    int want[6] = '{2, 2, 5, 5, 5, 5};
    int got[6];
    int k = 0, last = 0, c = 0;
    logic pv;
    pv = clk[12];
    while (clk[12] === pv && c < 10) begin step(); c++; end
    checks++;
    if (clk[12] === pv) begin errors++; $display("FAIL reprog_wait clk12 never toggled"); end
    cfg.cfg_we_i = 1; cfg.cfg_idx_i = 4'd12; cfg.cfg_hp_i = 5'd5;
    pv = clk[12];
    for (c = 1; c < 40 && k < 6; c++) begin
      step();
      cfg.cfg_we_i = 0;
      if (clk[12] !== pv) begin got[k] = c - last; last = c; k++; pv = clk[12]; end
    end
    checks++;
    if (k != 6 || got != want) begin
      errors++; $display("FAIL reprog_intervals count %0d got %p want %p", k, got, want);
    end
    for (int j = 0; j < 2; j++) begin
      cfg.cfg_we_i = 1;
      cfg.cfg_idx_i = j == 0 ? 4'd5 : 4'd13;
      cfg.cfg_hp_i = j == 0 ? 5'd0 : 5'd5;
      step();
      cfg.cfg_we_i = 0;
      checks++;
      if (cfg.cfg_err_o !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse case %0d err %b want 1", j, cfg.cfg_err_o); end
      step();
      checks++;
      if (cfg.cfg_err_o !== 1'b0) begin errors++; $display("FAIL cfg_err_clear case %0d err %b want 0", j, cfg.cfg_err_o); end
    end
    for (c = 0; c < 40; c++) begin
      step();
      checks++;
      if (clk !== mc || clk_h !== mh || cfg.cfg_err_o !== merr) begin
        errors++; $display("FAIL reprog_model cyc %0d clk %h/%h clk_h %h/%h", c, clk, mc, clk_h, mh);
      end
    end
  endtask

  task automatic test_disable_enable();
    int c = 0, ones = 0, rise = 0;
    while (clk[3] !== 1'b1 && c < 40) begin step(); c++; end
    checks++;
    if (clk[3] !== 1'b1) begin errors++; $display("FAIL dis_wait clk3 never high"); end
    ch_en[3] = 0;
    for (c = 0; c < 40; c++) begin
      step();
      if (c >= 15 && clk[3] !== 1'b0) ones++;
      checks++;
      if (clk !== mc || clk_h !== mh) begin
        errors++; $display("FAIL dis_model cyc %0d clk %h/%h clk_h %h/%h", c, clk, mc, clk_h, mh);
      end
    end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL dis_park clk3 high %0d cycles want 0", ones); end
    ch_en[3] = 1;
    step(); step(); step();
    checks++;
    if (clk[3] !== 1'b0) begin errors++; $display("FAIL en_a2 clk3 %b want 0", clk[3]); end
    step();
    checks++;
    if (clk[3] !== 1'b1) begin errors++; $display("FAIL en_a3 clk3 %b want 1", clk[3]); end
    for (c = 1; c <= 30 && rise == 0; c++) begin
      logic pv;
      pv = clk[3];
      step();
      if (clk[3] && !pv) rise = c;
    end
    checks++;
    if (rise != 22) begin errors++; $display("FAIL en_period clk3 period %0d want 22", rise); end
  endtask

  task automatic test_freeze();
    logic [N-1:0] hc, hh;
    int moved = 0;
    hc = clk; hh = clk_h;
    freeze = 1;
    for (int c = 0; c < 17; c++) begin
      step();
      if (clk !== hc || clk_h !== hh) moved++;
    end
    checks++;
    if (moved != 0) begin errors++; $display("FAIL freeze_hold moved %0d cycles want 0", moved); end
    freeze = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      checks++;
      if (clk !== mc || clk_h !== mh) begin
        errors++; $display("FAIL freeze_model cyc %0d clk %h/%h clk_h %h/%h", c, clk, mc, clk_h, mh);
      end
    end
  endtask

  task automatic test_async_reset();
    ch_en = '1;
    step(); #2;
    rst_ni = 0;
    #1;
    checks++;
    if (clk !== '0 || clk_h !== '0 || cfg.cfg_err_o !== 1'b0) begin
      errors++; $display("FAIL async_reset clk %h clk_h %h err %b want 0", clk, clk_h, cfg.cfg_err_o);
    end
    model_reset();
    @(negedge clk_i); rst_ni = 1;
    step(); step(); step();
    checks++;
    if (clk !== '0) begin errors++; $display("FAIL rst_e3 clk %h want 0", clk); end
    step();
    checks++;
    if (clk !== '1 || clk_h !== '0) begin errors++; $display("FAIL rst_e4 clk %h clk_h %h", clk, clk_h); end
    step();
    checks++;
    if (clk_h !== '1) begin errors++; $display("FAIL rst_e5 clk_h %h want 1fff", clk_h); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) freeze = ~freeze;
      cfg.cfg_we_i = $urandom_range(0, 7) == 0;
      cfg.cfg_idx_i = 4'($urandom_range(0, 15));
      cfg.cfg_hp_i = 5'($urandom_range(0, 31));
      step();
      checks++;
      if (clk !== mc || clk_h !== mh || cfg.cfg_err_o !== merr) begin
        errors++;
        $display("FAIL random_model cyc %0d clk %h/%h clk_h %h/%h err %b/%b", c, clk, mc, clk_h, mh, cfg.cfg_err_o, merr);
      end
    end
    freeze = 0; cfg.cfg_we_i = 0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_wrap();
    test_reprogram();
    test_disable_enable();
    test_freeze();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
